stage_id_hz: RTL and testbench
==============================

Name: stage_id_hz

Overview:
- Next-generation instruction decode stage for the MIPS-subset pipeline, between stage_if and stage_ex.
- Adds what the current decoder lacks: a valid bit, load-use interlock (stall), branch flush, and EX/MEM/WB operand bypassing, with a parameter that selects bypass mode or stall-only mode.
- Decodes R-type, BEQ, BNE, ADDIU, ORI, LUI, LW and SW into a registered ID/EX bundle.

Parameters:
- DATA_WIDTH, 32, register/data width; instruction word stays 32 bits.
- REGADDR_WIDTH, 5, register index width.
- ENABLE_FWD, 1: 1 = bypass from EX/MEM/WB; 0 = stall on any RAW hazard against EX/MEM/WB.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  if_instr and if_next_pc are valid.
- if_instr  in  32  instruction word.
- if_next_pc  in  32  PC+4 of the instruction.
- flush  in  1  taken branch resolved in EX; kill the instruction in ID.
- id_stall  out  1  combinational; IF must hold PC and instruction.
- ex_wb_addr  in  REGADDR_WIDTH  destination of the instruction now in EX (0 = none).
- ex_is_load  in  1  EX instruction is a LW.
- ex_result  in  DATA_WIDTH  EX ALU result.
- mem_wb_addr  in  REGADDR_WIDTH  destination of the instruction in MEM.
- mem_result  in  DATA_WIDTH  MEM-stage writeback value.
- reg_write_addr  in  REGADDR_WIDTH  WB write index; 0 disables the write.
- reg_write_data  in  DATA_WIDTH  WB write data.
- id_valid  out  1  ID/EX bundle is valid.
- alu_opt  out  6  ALU operation; ALU_OPT_DISABLE for a bubble.
- alu_src  out  1  ALU_SRC_REG or ALU_SRC_IMM.
- alu_sa_imm  out  DATA_WIDTH  shift amount or extended immediate.
- reg1_data, reg2_data  out  DATA_WIDTH  resolved operands.
- wb_reg_addr  out  REGADDR_WIDTH  destination register; 0 = no writeback.
- wb_src  out  2  WB_SRC_ALU or WB_SRC_MEM.
- mem_opt  out  2  MEM_OPT_NONE, MEM_OPT_LOAD or MEM_OPT_STORE.
- branch_opt  out  2  BRANCH_NONE, BRANCH_ON_ALU_EQZ or BRANCH_ON_ALU_NEZ.
- branch_dest  out  32  if_next_pc + (sign-extended imm << 2).
- debug_out  out  32  passed through from register_file.

Behaviour:
- Reset:
  - All ID/EX outputs are cleared to bubble values: id_valid=0, alu_opt=ALU_OPT_DISABLE, wb_reg_addr=0, mem_opt=NONE, branch_opt=NONE; data fields=0.
  - Register file is cleared.
  - rst has priority over flush and stall.
- Latency: one cycle. The bundle for the instruction in ID appears on the next edge.
- Sources used:
  - rs for all decoded opcodes except LUI.
  - rt for R-type, BEQ, BNE and SW.
  - A source index of 0 never causes a hazard.
- Stall conditions (id_stall=1):
  - Load-use: ex_is_load and ex_wb_addr matches a used source.
  - When ENABLE_FWD=0: additionally, any used-source match with ex_wb_addr, mem_wb_addr or reg_write_addr.
- Effect of a stall:
  - The next edge registers a bubble.
  - IF holds, so the same instruction is re-decoded in the following cycle.
- Flush: if flush=1 at an edge, the edge registers a bubble and id_stall is forced to 0. Flush beats stall.
- !if_valid: the edge registers a bubble.
- Operand resolution (ENABLE_FWD=1), per source, highest priority first:
  - ex_result, on ex_wb_addr match and not a load.
  - mem_result, on mem_wb_addr match.
  - reg_write_data, on reg_write_addr match (same-cycle WB bypass).
  - Register file read data.
  - Index 0 always yields 0.
- Decode:
  - R-type: alu_opt=func, alu_src=REG, alu_sa_imm=sa, wb_reg_addr=rd, wb_src=ALU.
  - BEQ/BNE: alu_opt=SUBU, alu_src=REG, branch_opt=EQZ/NEZ, no writeback.
  - ADDIU: sign-extended imm, ADDU, wb_reg_addr=rt.
  - ORI: zero-extended imm, OR, wb_reg_addr=rt.
  - LUI: imm<<16, OR with reg1=0, wb_reg_addr=rt.
  - LW: ADDU with sign-extended imm, mem_opt=LOAD, wb_src=MEM, wb_reg_addr=rt.
  - SW: ADDU with sign-extended imm, mem_opt=STORE, reg2=store data, no writeback.
  - Any unlisted opcode decodes to a bubble, id_valid=0.
- Width rules:
  - Immediates extend to DATA_WIDTH.
  - branch_dest is a 32-bit wrap-around add.

Decomposition:
- Shared constants stay in alu_opt.vh, branch_opt.vh, wb_src.vh and mem_opt.vh. Add BRANCH_ON_ALU_NEZ and MEM_OPT_STORE there if not already defined.
- Reuse the existing register_file sub-module.
- New sub-module id_hazard_unit: combinational stall and bypass select, parametrised by ENABLE_FWD.

Test Plan:
- Reset while a LW sits in ID -> next cycle id_valid=0, alu_opt=DISABLE, wb_reg_addr=0, id_stall=0.
- ADDIU $2,$0,0x8001 -> alu_sa_imm=0xFFFF8001, wb_reg_addr=2, one-cycle latency. ORI $2,$0,0x8001 -> alu_sa_imm=0x00008001.
- EX holds LW $3 (ex_is_load=1, ex_wb_addr=3), ID holds ADDU $4,$3,$1 -> id_stall=1 for exactly one cycle, one bubble emitted, then reg1_data=mem_result=0x1234.
- EX writes $5=0xA, MEM writes $5=0xB, ID reads $5 -> reg1_data=0xA. Same stimulus with ENABLE_FWD=0 -> stalls until WB completes, then 0xA.
- flush=1 while stall conditions are present -> bubble, id_stall=0.
- BEQ at next_pc=0x0000_0010 with imm=0xFFFF -> branch_dest=0x0000_000C, branch_opt=EQZ, wb_reg_addr=0.

Source files
------------

// File: rtl/stage_id_hz_pkg.sv
// stage_id_hz_pkg: shared encodings and decode helpers for the ID stage
package stage_id_hz_pkg;
  localparam logic [5:0] ALU_OPT_DISABLE = 6'h3f;
  localparam logic [5:0] ALU_OPT_ADDU = 6'h21;
  localparam logic [5:0] ALU_OPT_SUBU = 6'h23;
  localparam logic [5:0] ALU_OPT_OR = 6'h25;
  localparam logic ALU_SRC_REG = 1'b0;
  localparam logic ALU_SRC_IMM = 1'b1;
  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MEM = 2'd1;
  localparam logic [1:0] MEM_OPT_NONE = 2'd0;
  localparam logic [1:0] MEM_OPT_LOAD = 2'd1;
  localparam logic [1:0] MEM_OPT_STORE = 2'd2;
  localparam logic [1:0] BRANCH_NONE = 2'd0;
  localparam logic [1:0] BRANCH_ON_ALU_EQZ = 2'd1;
  localparam logic [1:0] BRANCH_ON_ALU_NEZ = 2'd2;
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ = 6'h04,
    OP_BNE = 6'h05,
    OP_ADDIU = 6'h09,
    OP_ORI = 6'h0d,
    OP_LUI = 6'h0f,
    OP_LW = 6'h23,
    OP_SW = 6'h2b
  } opcode_e;
  typedef enum logic [2:0] {FWD_RF, FWD_EX, FWD_MEM, FWD_WB, FWD_ZERO} fwd_sel_e;
  function automatic logic uses_rs(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDIU, OP_ORI, OP_LW, OP_SW};
  endfunction
  function automatic logic uses_rt(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
  endfunction
endpackage

// File: rtl/id_hazard_unit.sv
// id_hazard_unit: load-use / RAW stall detection and operand bypass selection
module id_hazard_unit
  import stage_id_hz_pkg::*;
#(
  parameter int REGADDR_WIDTH = 5,
  parameter bit ENABLE_FWD = 1'b1
) (
  input logic use_rs,
  input logic use_rt,
  input logic flush,
  input logic ex_is_load,
  input logic [REGADDR_WIDTH-1:0] rs,
  input logic [REGADDR_WIDTH-1:0] rt,
  input logic [REGADDR_WIDTH-1:0] ex_wb_addr,
  input logic [REGADDR_WIDTH-1:0] mem_wb_addr,
  input logic [REGADDR_WIDTH-1:0] reg_write_addr,
  output logic stall,
  output fwd_sel_e sel_rs,
  output fwd_sel_e sel_rt
);
  logic [1:0] used, m_ex, m_mem, m_wb;
  assign used = {use_rt && rt != '0, use_rs && rs != '0};
  assign m_ex = used & {rt == ex_wb_addr, rs == ex_wb_addr};
  assign m_mem = used & {rt == mem_wb_addr, rs == mem_wb_addr};
  assign m_wb = used & {rt == reg_write_addr, rs == reg_write_addr};
  assign stall = !flush && (ENABLE_FWD ? ex_is_load && |m_ex : |(m_ex | m_mem | m_wb));
  function automatic fwd_sel_e pick(input logic u, input logic e, input logic m, input logic w);
    return !u ? FWD_ZERO : !ENABLE_FWD ? FWD_RF : (e && !ex_is_load) ? FWD_EX : m ? FWD_MEM : w ? FWD_WB : FWD_RF;
  endfunction
  assign sel_rs = pick(used[0], m_ex[0], m_mem[0], m_wb[0]);
  assign sel_rt = pick(used[1], m_ex[1], m_mem[1], m_wb[1]);
endmodule

// File: rtl/register_file.sv
// register_file: 2-read 1-write register file with $0 hardwired and a debug tap
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int REGADDR_WIDTH = 5
) (
  input logic clk,
  input logic rst,
  input logic [REGADDR_WIDTH-1:0] raddr1,
  input logic [REGADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  input logic [REGADDR_WIDTH-1:0] waddr,
  input logic [DATA_WIDTH-1:0] wdata,
  output logic [31:0] debug_out
);
  logic [DATA_WIDTH-1:0] regs [2**REGADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**REGADDR_WIDTH; i++) regs[i] <= '0;
    end else if (waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end
  assign rdata1 = raddr1 == '0 ? '0 : regs[raddr1];
  assign rdata2 = raddr2 == '0 ? '0 : regs[raddr2];
  assign debug_out = 32'(regs[1]);
endmodule

// File: rtl/stage_id_hz.sv
// stage_id_hz: MIPS-subset decode stage with interlock, flush and operand bypass
module stage_id_hz
  import stage_id_hz_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REGADDR_WIDTH = 5,
  parameter bit ENABLE_FWD = 1'b1
) (
  input logic clk,
  input logic rst,
  input logic if_valid,
  input logic [31:0] if_instr,
  input logic [31:0] if_next_pc,
  input logic flush,
  output logic id_stall,
  input logic [REGADDR_WIDTH-1:0] ex_wb_addr,
  input logic ex_is_load,
  input logic [DATA_WIDTH-1:0] ex_result,
  input logic [REGADDR_WIDTH-1:0] mem_wb_addr,
  input logic [DATA_WIDTH-1:0] mem_result,
  input logic [REGADDR_WIDTH-1:0] reg_write_addr,
  input logic [DATA_WIDTH-1:0] reg_write_data,
  output logic id_valid,
  output logic [5:0] alu_opt,
  output logic alu_src,
  output logic [DATA_WIDTH-1:0] alu_sa_imm,
  output logic [DATA_WIDTH-1:0] reg1_data,
  output logic [DATA_WIDTH-1:0] reg2_data,
  output logic [REGADDR_WIDTH-1:0] wb_reg_addr,
  output logic [1:0] wb_src,
  output logic [1:0] mem_opt,
  output logic [1:0] branch_opt,
  output logic [31:0] branch_dest,
  output logic [31:0] debug_out
);
  logic [5:0] op, func;
  logic [15:0] imm;
  logic [REGADDR_WIDTH-1:0] rs, rt, rd;
  logic [DATA_WIDTH-1:0] imm_sx, rf1, rf2;
  logic use_rs, use_rt, hz_stall, kill;
  fwd_sel_e sel_rs, sel_rt;
  logic d_valid, d_alu_src;
  logic [5:0] d_alu_opt;
  logic [DATA_WIDTH-1:0] d_imm;
  logic [REGADDR_WIDTH-1:0] d_wb;
  logic [1:0] d_wb_src, d_mem, d_br;
  assign op = if_instr[31:26];
  assign rs = REGADDR_WIDTH'(if_instr[25:21]);
  assign rt = REGADDR_WIDTH'(if_instr[20:16]);
  assign rd = REGADDR_WIDTH'(if_instr[15:11]);
  assign func = if_instr[5:0];
  assign imm = if_instr[15:0];
  assign imm_sx = {{(DATA_WIDTH-16){imm[15]}}, imm};
  assign use_rs = if_valid && uses_rs(op);
  assign use_rt = if_valid && uses_rt(op);
  always_comb begin
    d_valid = 1'b1;
    d_alu_opt = ALU_OPT_ADDU;
    d_alu_src = ALU_SRC_IMM;
    d_imm = imm_sx;
    d_wb = rt;
    d_wb_src = WB_SRC_ALU;
    d_mem = MEM_OPT_NONE;
    d_br = BRANCH_NONE;
    case (op)
      OP_RTYPE: begin
        d_alu_opt = func;
        d_alu_src = ALU_SRC_REG;
        d_imm = DATA_WIDTH'(if_instr[10:6]);
        d_wb = rd;
      end
      OP_BEQ, OP_BNE: begin
        d_alu_opt = ALU_OPT_SUBU;
        d_alu_src = ALU_SRC_REG;
        d_imm = '0;
        d_wb = '0;
        d_br = op == OP_BEQ ? BRANCH_ON_ALU_EQZ : BRANCH_ON_ALU_NEZ;
      end
      OP_ADDIU: d_alu_opt = ALU_OPT_ADDU;
      OP_ORI: begin
        d_alu_opt = ALU_OPT_OR;
        d_imm = DATA_WIDTH'(imm);
      end
      OP_LUI: begin
        d_alu_opt = ALU_OPT_OR;
        d_imm = DATA_WIDTH'({imm, 16'h0000});
      end
      OP_LW: begin
        d_mem = MEM_OPT_LOAD;
        d_wb_src = WB_SRC_MEM;
      end
      OP_SW: begin
        d_mem = MEM_OPT_STORE;
        d_wb = '0;
      end
      default: d_valid = 1'b0;
    endcase
  end
  register_file #(.DATA_WIDTH(DATA_WIDTH), .REGADDR_WIDTH(REGADDR_WIDTH)) u_rf (
    .clk(clk),
    .rst(rst),
    .raddr1(rs),
    .raddr2(rt),
    .rdata1(rf1),
    .rdata2(rf2),
    .waddr(reg_write_addr),
    .wdata(reg_write_data),
    .debug_out(debug_out)
  );
  id_hazard_unit #(.REGADDR_WIDTH(REGADDR_WIDTH), .ENABLE_FWD(ENABLE_FWD)) u_hz (
    .use_rs(use_rs),
    .use_rt(use_rt),
    .flush(flush),
    .ex_is_load(ex_is_load),
    .rs(rs),
    .rt(rt),
    .ex_wb_addr(ex_wb_addr),
    .mem_wb_addr(mem_wb_addr),
    .reg_write_addr(reg_write_addr),
    .stall(hz_stall),
    .sel_rs(sel_rs),
    .sel_rt(sel_rt)
  );
  function automatic logic [DATA_WIDTH-1:0] resolve(input fwd_sel_e s, input logic [DATA_WIDTH-1:0] rf);
    return s == FWD_EX ? ex_result : s == FWD_MEM ? mem_result : s == FWD_WB ? reg_write_data : s == FWD_RF ? rf : '0;
  endfunction
  assign id_stall = !rst && hz_stall;
  assign kill = !if_valid || !d_valid || hz_stall || flush;
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      id_valid <= 1'b0;
      alu_opt <= ALU_OPT_DISABLE;
      alu_src <= ALU_SRC_REG;
      alu_sa_imm <= '0;
      reg1_data <= '0;
      reg2_data <= '0;
      wb_reg_addr <= '0;
      wb_src <= WB_SRC_ALU;
      mem_opt <= MEM_OPT_NONE;
      branch_opt <= BRANCH_NONE;
      branch_dest <= '0;
    end else begin
      id_valid <= 1'b1;
      alu_opt <= d_alu_opt;
      alu_src <= d_alu_src;
      alu_sa_imm <= d_imm;
      reg1_data <= resolve(sel_rs, rf1);
      reg2_data <= resolve(sel_rt, rf2);
      wb_reg_addr <= d_wb;
      wb_src <= d_wb_src;
      mem_opt <= d_mem;
      branch_opt <= d_br;
      branch_dest <= if_next_pc + {{14{imm[15]}}, imm, 2'b00};
    end
  end
endmodule

// File: tb/tb_stage_id_hz.sv
// tb_stage_id_hz: directed checks of decode, interlock, flush and bypass in both modes
module tb_stage_id_hz;
  logic clk, rst, if_valid, flush, ex_is_load;
  logic [31:0] if_instr, if_next_pc;
  logic [4:0] ex_wb_addr, mem_wb_addr, reg_write_addr;
  logic [31:0] ex_result, mem_result, reg_write_data;
  logic id_stall, id_valid, alu_src;
  logic [5:0] alu_opt;
  logic [31:0] alu_sa_imm, reg1_data, reg2_data, branch_dest, debug_out;
  logic [4:0] wb_reg_addr;
  logic [1:0] wb_src, mem_opt, branch_opt;
  logic s_id_stall, s_id_valid, s_alu_src;
  logic [5:0] s_alu_opt;
  logic [31:0] s_alu_sa_imm, s_reg1_data, s_reg2_data, s_branch_dest, s_debug_out;
  logic [4:0] s_wb_reg_addr;
  logic [1:0] s_wb_src, s_mem_opt, s_branch_opt;
  int vectors, miscompares;
  stage_id_hz #(.ENABLE_FWD(1'b1)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_next_pc(if_next_pc),
    .flush(flush), .id_stall(id_stall), .ex_wb_addr(ex_wb_addr), .ex_is_load(ex_is_load),
    .ex_result(ex_result), .mem_wb_addr(mem_wb_addr), .mem_result(mem_result),
    .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data), .id_valid(id_valid),
    .alu_opt(alu_opt), .alu_src(alu_src), .alu_sa_imm(alu_sa_imm), .reg1_data(reg1_data),
    .reg2_data(reg2_data), .wb_reg_addr(wb_reg_addr), .wb_src(wb_src), .mem_opt(mem_opt),
    .branch_opt(branch_opt), .branch_dest(branch_dest), .debug_out(debug_out)
  );
  stage_id_hz #(.ENABLE_FWD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_next_pc(if_next_pc),
    .flush(flush), .id_stall(s_id_stall), .ex_wb_addr(ex_wb_addr), .ex_is_load(ex_is_load),
    .ex_result(ex_result), .mem_wb_addr(mem_wb_addr), .mem_result(mem_result),
    .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data), .id_valid(s_id_valid),
    .alu_opt(s_alu_opt), .alu_src(s_alu_src), .alu_sa_imm(s_alu_sa_imm), .reg1_data(s_reg1_data),
    .reg2_data(s_reg2_data), .wb_reg_addr(s_wb_reg_addr), .wb_src(s_wb_src), .mem_opt(s_mem_opt),
    .branch_opt(s_branch_opt), .branch_dest(s_branch_dest), .debug_out(s_debug_out)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    flush = 1'b0;
    ex_wb_addr = 5'd0;
    ex_is_load = 1'b0;
    ex_result = 32'h0;
    mem_wb_addr = 5'd0;
    mem_result = 32'h0;
    reg_write_addr = 5'd0;
    reg_write_data = 32'h0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    idle();
    if_valid = 1'b1;
    if_instr = 32'h8C230000;
    if_next_pc = 32'h4;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %h want %h", id_valid, 1'b0); end
    vectors++; if (alu_opt !== 6'h3f) begin miscompares++; $display("FAIL reset_alu_opt: got %h want %h", alu_opt, 6'h3f); end
    vectors++; if (wb_reg_addr !== 5'd0) begin miscompares++; $display("FAIL reset_wb_addr: got %h want %h", wb_reg_addr, 5'd0); end
    vectors++; if (mem_opt !== 2'd0) begin miscompares++; $display("FAIL reset_mem_opt: got %h want %h", mem_opt, 2'd0); end
    vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %h want %h", id_stall, 1'b0); end
    vectors++; if (debug_out !== 32'h0) begin miscompares++; $display("FAIL reset_debug: got %h want %h", debug_out, 32'h0); end
  endtask
  task automatic test_imm;
    rst = 1'b0;
    if_instr = 32'h24028001;
    #1;
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL addiu_latency: got %h want %h", id_valid, 1'b0); end
    tick();
    vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("FAIL addiu_valid: got %h want %h", id_valid, 1'b1); end
    vectors++; if (alu_sa_imm !== 32'hFFFF8001) begin miscompares++; $display("FAIL addiu_imm: got %h want %h", alu_sa_imm, 32'hFFFF8001); end
    vectors++; if (wb_reg_addr !== 5'd2) begin miscompares++; $display("FAIL addiu_wb: got %h want %h", wb_reg_addr, 5'd2); end
    vectors++; if (alu_opt !== 6'h21 || alu_src !== 1'b1) begin miscompares++; $display("FAIL addiu_alu: got %h/%h want 21/1", alu_opt, alu_src); end
    if_instr = 32'h34028001;
    tick();
    vectors++; if (alu_sa_imm !== 32'h00008001) begin miscompares++; $display("FAIL ori_imm: got %h want %h", alu_sa_imm, 32'h00008001); end
    vectors++; if (alu_opt !== 6'h25) begin miscompares++; $display("FAIL ori_alu: got %h want %h", alu_opt, 6'h25); end
    if_instr = 32'h3C071234;
    tick();
    vectors++; if (alu_sa_imm !== 32'h12340000 || wb_reg_addr !== 5'd7) begin miscompares++; $display("FAIL lui: got %h/%h want 12340000/07", alu_sa_imm, wb_reg_addr); end
    if_instr = 32'h8D280010;
    tick();
    vectors++; if (mem_opt !== 2'd1 || wb_src !== 2'd1 || wb_reg_addr !== 5'd8) begin miscompares++; $display("FAIL lw: got %h/%h/%h want 1/1/08", mem_opt, wb_src, wb_reg_addr); end
    if_instr = 32'hAC060004;
    ex_wb_addr = 5'd6;
    ex_result = 32'h55;
    tick();
    vectors++; if (mem_opt !== 2'd2 || wb_reg_addr !== 5'd0 || reg2_data !== 32'h55) begin miscompares++; $display("FAIL sw: got %h/%h/%h want 2/00/00000055", mem_opt, wb_reg_addr, reg2_data); end
    idle();
    if_instr = 32'h000148C0;
    tick();
    vectors++; if (alu_opt !== 6'h00 || alu_src !== 1'b0 || alu_sa_imm !== 32'h3 || wb_reg_addr !== 5'd9) begin miscompares++; $display("FAIL rtype_sll: got %h/%h/%h/%h want 00/0/00000003/09", alu_opt, alu_src, alu_sa_imm, wb_reg_addr); end
  endtask
  task automatic test_load_use;
    idle();
    if_instr = 32'h00612021;
    ex_wb_addr = 5'd3;
    ex_is_load = 1'b1;
    #1;
    vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL loaduse_stall: got %h want %h", id_stall, 1'b1); end
    tick();
    vectors++; if (id_valid !== 1'b0 || alu_opt !== 6'h3f) begin miscompares++; $display("FAIL loaduse_bubble: got %h/%h want 0/3f", id_valid, alu_opt); end
    ex_wb_addr = 5'd0;
    ex_is_load = 1'b0;
    mem_wb_addr = 5'd3;
    mem_result = 32'h1234;
    #1;
    vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL loaduse_release: got %h want %h", id_stall, 1'b0); end
    tick();
    vectors++; if (id_valid !== 1'b1 || reg1_data !== 32'h1234 || wb_reg_addr !== 5'd4) begin miscompares++; $display("FAIL loaduse_fwd: got %h/%h/%h want 1/00001234/04", id_valid, reg1_data, wb_reg_addr); end
  endtask
  task automatic test_bypass;
    idle();
    if_instr = 32'h00A03021;
    ex_wb_addr = 5'd5;
    ex_result = 32'hA;
    mem_wb_addr = 5'd5;
    mem_result = 32'hB;
    #1;
    vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL fwd_nostall: got %h want %h", id_stall, 1'b0); end
    vectors++; if (s_id_stall !== 1'b1) begin miscompares++; $display("FAIL nofwd_stall_ex: got %h want %h", s_id_stall, 1'b1); end
    tick();
    vectors++; if (reg1_data !== 32'hA) begin miscompares++; $display("FAIL fwd_ex_over_mem: got %h want %h", reg1_data, 32'hA); end
    vectors++; if (s_id_valid !== 1'b0) begin miscompares++; $display("FAIL nofwd_bubble: got %h want %h", s_id_valid, 1'b0); end
    ex_wb_addr = 5'd0;
    ex_result = 32'h0;
    mem_result = 32'hA;
    #1;
    vectors++; if (s_id_stall !== 1'b1) begin miscompares++; $display("FAIL nofwd_stall_mem: got %h want %h", s_id_stall, 1'b1); end
    tick();
    vectors++; if (reg1_data !== 32'hA) begin miscompares++; $display("FAIL fwd_mem: got %h want %h", reg1_data, 32'hA); end
    mem_wb_addr = 5'd0;
    mem_result = 32'h0;
    reg_write_addr = 5'd5;
    reg_write_data = 32'hA;
    #1;
    vectors++; if (s_id_stall !== 1'b1) begin miscompares++; $display("FAIL nofwd_stall_wb: got %h want %h", s_id_stall, 1'b1); end
    tick();
    vectors++; if (reg1_data !== 32'hA) begin miscompares++; $display("FAIL fwd_wb: got %h want %h", reg1_data, 32'hA); end
    reg_write_addr = 5'd0;
    reg_write_data = 32'h0;
    #1;
    vectors++; if (s_id_stall !== 1'b0) begin miscompares++; $display("FAIL nofwd_release: got %h want %h", s_id_stall, 1'b0); end
    tick();
    vectors++; if (s_id_valid !== 1'b1 || s_reg1_data !== 32'hA) begin miscompares++; $display("FAIL nofwd_result: got %h/%h want 1/0000000a", s_id_valid, s_reg1_data); end
    vectors++; if (reg1_data !== 32'hA) begin miscompares++; $display("FAIL fwd_regfile: got %h want %h", reg1_data, 32'hA); end
  endtask
  task automatic test_flush;
    idle();
    if_instr = 32'h00612021;
    ex_wb_addr = 5'd3;
    ex_is_load = 1'b1;
    flush = 1'b1;
    #1;
    vectors++; if (id_stall !== 1'b0 || s_id_stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall: got %h/%h want 0/0", id_stall, s_id_stall); end
    tick();
    vectors++; if (id_valid !== 1'b0 || alu_opt !== 6'h3f) begin miscompares++; $display("FAIL flush_bubble: got %h/%h want 0/3f", id_valid, alu_opt); end
    flush = 1'b0;
    #1;
    vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL flush_release: got %h want %h", id_stall, 1'b1); end
    if_valid = 1'b0;
    #1;
    vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL invalid_stall: got %h want %h", id_stall, 1'b0); end
    idle();
    if_instr = 32'h24028001;
    tick();
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL invalid_bubble: got %h want %h", id_valid, 1'b0); end
    if_valid = 1'b1;
  endtask
  task automatic test_branch;
    idle();
    if_instr = 32'h1022FFFF;
    if_next_pc = 32'h00000010;
    tick();
    vectors++; if (branch_dest !== 32'h0000000C) begin miscompares++; $display("FAIL beq_dest: got %h want %h", branch_dest, 32'h0000000C); end
    vectors++; if (branch_opt !== 2'd1 || wb_reg_addr !== 5'd0 || alu_opt !== 6'h23) begin miscompares++; $display("FAIL beq_ctl: got %h/%h/%h want 1/00/23", branch_opt, wb_reg_addr, alu_opt); end
    if_instr = 32'h14220003;
    if_next_pc = 32'h00000020;
    tick();
    vectors++; if (branch_opt !== 2'd2 || branch_dest !== 32'h0000002C) begin miscompares++; $display("FAIL bne: got %h/%h want 2/0000002c", branch_opt, branch_dest); end
    if_instr = 32'h08000000;
    tick();
    vectors++; if (id_valid !== 1'b0 || alu_opt !== 6'h3f) begin miscompares++; $display("FAIL unknown_op: got %h/%h want 0/3f", id_valid, alu_opt); end
  endtask
  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_imm();
    test_load_use();
    test_bypass();
    test_flush();
    test_branch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
